instr_loader: RTL and testbench

Program loader and instruction store sitting directly upstream of the 8-bit single-cycle core. It accepts a program byte-stream over a valid/ready write port into an internal instruction RAM, then serves `instruction` for the core's `ReadAddress`. It gates the core via `cpu_run` and halts the core when the PC runs past the loaded program. The block runs on the undivided board clock; the core's divided clock is far slower than the 1-cycle read latency.

---
 rtl/instr_loader_pkg.sv | 13 +
 rtl/instr_ram.sv | 26 ++
 rtl/instr_loader.sv | 111 +++++++++++
 tb/tb_instr_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared constants for the program loader: FSM encoding, state width and default filler word.
package instr_loader_pkg;

   localparam int         STATE_W = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   localparam logic [7:0] NOP_WORD_DEFAULT = 8'h00;

endpackage

// File: rtl/instr_ram.sv
// DEPTH x 8 instruction store: one synchronous write port, one registered read port.
module instr_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];
   logic [7:0] rd_data_reg;

   // No reset so the array and read register map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_loader.sv
// Program loader / instruction store feeding the 8-bit core; gates and halts the core.
// Optional running byte checksum is built only when LOADER_CHECKSUM_EN is defined.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int         DEPTH    = 256,
   parameter logic [7:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic               clk50,
   input  logic               reset,
   input  logic               load_start,
   input  logic               load_done,
   input  logic               wr_valid,
   input  logic [7:0]         wr_data,
   output logic               wr_ready,
   input  logic [7:0]         read_address,
   output logic [7:0]         instruction,
   output logic               cpu_run,
   output logic [8:0]         prog_len,
   output logic               overflow,
   output logic [STATE_W-1:0] state,
   output logic [7:0]         checksum
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0] state_reg, state_next;
   logic [8:0] prog_len_reg, prog_len_next;
   logic       overflow_reg, overflow_next;
   logic       valid_reg, valid_next;
   logic       full, accept, in_range;
   logic [8:0] len_after;
   logic [7:0] ram_q;

   always_comb begin
      full      = (prog_len_reg == 9'(DEPTH));
      wr_ready  = (state_reg == ST_LOAD) && !full;
      // A restart pulse wins over any byte offered in the same cycle.
      accept    = wr_ready && wr_valid && !load_start;
      len_after = prog_len_reg + 9'(accept);
      in_range  = ({1'b0, read_address} < prog_len_reg);

      state_next    = state_reg;
      prog_len_next = len_after;
      overflow_next = overflow_reg | ((state_reg == ST_LOAD) && wr_valid && full);
      valid_next    = (state_reg == ST_RUN) && in_range && !load_start;

      if (load_start) begin
         state_next    = ST_LOAD;
         prog_len_next = '0;
         overflow_next = 1'b0;
      end else begin
         case (state_reg)
            ST_LOAD: if (load_done) state_next = (len_after != '0) ? ST_RUN : ST_IDLE;
            ST_RUN:  if (!in_range) state_next = ST_HALT;
            default: state_next = state_reg;
         endcase
      end
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         prog_len_reg <= '0;
         overflow_reg <= 1'b0;
         valid_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         prog_len_reg <= prog_len_next;
         overflow_reg <= overflow_next;
         valid_reg    <= valid_next;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum_reg;

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset)
         checksum_reg <= '0;
      else if (load_start)
         checksum_reg <= '0;
      else if (accept)
         checksum_reg <= checksum_reg + wr_data;
   end

   assign checksum = checksum_reg;
`else
   assign checksum = '0;
`endif

   instr_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk50),
      .wr_en   (accept),
      .wr_addr (prog_len_reg[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (read_address[AW-1:0]),
      .rd_data (ram_q)
   );

   // valid_reg travels alongside the RAM read register, so the pair forms the registered word.
   assign instruction = valid_reg ? ram_q : NOP_WORD;
   assign cpu_run     = (state_reg == ST_RUN);
   assign prog_len    = prog_len_reg;
   assign overflow    = overflow_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; expectations are hand-derived constants or a byte-sum model.
module tb_instr_loader;

   logic       clk50 = 1'b0;
   logic       reset = 1'b0;
   logic       load_start = 1'b0;
   logic       load_done = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic [7:0] read_address = 8'h00;
   logic [7:0] instruction;
   logic       cpu_run;
   logic [8:0] prog_len;
   logic       overflow;
   logic [1:0] state;
   logic [7:0] checksum;

   int check_count = 0;
   int error_count = 0;

   instr_loader dut (
      .clk50        (clk50),
      .reset        (reset),
      .load_start   (load_start),
      .load_done    (load_done),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .read_address (read_address),
      .instruction  (instruction),
      .cpu_run      (cpu_run),
      .prog_len     (prog_len),
      .overflow     (overflow),
      .state        (state),
      .checksum     (checksum)
   );

   always #5 clk50 = ~clk50;

   task automatic tick();
      @(posedge clk50);
      @(negedge clk50);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) else begin
         error_count++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
      return s;
`else
      return 8'h00 & s;
`endif
   endfunction

   function automatic logic [7:0] big_byte(input int i);
      return 8'((i * 7) + 3);
   endfunction

   initial begin
      logic [7:0] sum;

      // Reset values
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_instruction", 32'(instruction), 32'h00);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_prog_len", 32'(prog_len), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_checksum", 32'(checksum), 32'd0);
      reset = 1'b1;
      tick();

      // IDLE ignores writes
      wr_valid = 1'b1; wr_data = 8'h77;
      tick();
      wr_valid = 1'b0;
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_prog_len", 32'(prog_len), 32'd0);
      $display("txn idle_ignore state=%0d prog_len=%0d", state, prog_len);

      // Load three bytes and run
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("load_state", 32'(state), 32'd1);
      chk("load_wr_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1; wr_data = 8'h41; tick();
      wr_data = 8'h12; tick();
      wr_data = 8'hC3; tick();
      wr_valid = 1'b0;
      chk("load3_prog_len", 32'(prog_len), 32'd3);
      chk("load3_checksum", 32'(checksum), 32'(exp_sum(8'h16)));
      $display("txn load3 prog_len=%0d checksum=%02h", prog_len, checksum);
      load_done = 1'b1; read_address = 8'd1;
      tick();
      load_done = 1'b0;
      chk("run_state", 32'(state), 32'd2);
      chk("run_cpu_run", 32'(cpu_run), 32'd1);
      tick();
      chk("run_rd1", 32'(instruction), 32'h12);
      read_address = 8'd0; tick();
      chk("run_rd0", 32'(instruction), 32'h41);
      read_address = 8'd2; tick();
      chk("run_rd2", 32'(instruction), 32'hC3);
      $display("txn run_reads last_instruction=%02h", instruction);

      // Past end of program halts
      read_address = 8'd3; tick();
      chk("halt_instruction", 32'(instruction), 32'h00);
      chk("halt_state", 32'(state), 32'd3);
      chk("halt_cpu_run", 32'(cpu_run), 32'd0);
      read_address = 8'd0; tick();
      chk("halt_sticky_state", 32'(state), 32'd3);
      chk("halt_sticky_instr", 32'(instruction), 32'h00);
      $display("txn halt state=%0d cpu_run=%0d", state, cpu_run);

      // Asynchronous reset while running with five bytes
      load_start = 1'b1; tick(); load_start = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'h20 + i);
         tick();
      end
      wr_valid = 1'b0;
      load_done = 1'b1; tick(); load_done = 1'b0;
      read_address = 8'd4; tick();
      chk("pre_rst_prog_len", 32'(prog_len), 32'd5);
      chk("pre_rst_instr", 32'(instruction), 32'h24);
      #2 reset = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_cpu_run", 32'(cpu_run), 32'd0);
      chk("arst_instruction", 32'(instruction), 32'h00);
      chk("arst_prog_len", 32'(prog_len), 32'd0);
      $display("txn async_reset state=%0d prog_len=%0d", state, prog_len);
      @(negedge clk50);
      reset = 1'b1;
      read_address = 8'd0;
      tick();

      // Fill all 256 words, then offer one more
      load_start = 1'b1; tick(); load_start = 1'b0;
      sum = 8'h00;
      wr_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wr_data = big_byte(i);
         sum = sum + big_byte(i);
         tick();
      end
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      chk("full_overflow_pre", 32'(overflow), 32'd0);
      wr_data = 8'hEE;
      tick();
      wr_valid = 1'b0;
      chk("ovf_prog_len", 32'(prog_len), 32'd256);
      chk("ovf_overflow", 32'(overflow), 32'd1);
      chk("ovf_wr_ready", 32'(wr_ready), 32'd0);
      chk("ovf_checksum", 32'(checksum), 32'(exp_sum(sum)));
      $display("txn fill256 prog_len=%0d overflow=%0d", prog_len, overflow);
      load_done = 1'b1; read_address = 8'd255; tick(); load_done = 1'b0;
      tick();
      chk("ovf_ram255", 32'(instruction), 32'(big_byte(255)));
      read_address = 8'd0; tick();
      chk("ovf_ram0", 32'(instruction), 32'(big_byte(0)));
      chk("ovf_run_state", 32'(state), 32'd2);

      // Reload from RUN drops cpu_run and clears the count the same edge
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("reload_state", 32'(state), 32'd1);
      chk("reload_cpu_run", 32'(cpu_run), 32'd0);
      chk("reload_prog_len", 32'(prog_len), 32'd0);
      chk("reload_overflow", 32'(overflow), 32'd0);
      chk("reload_checksum", 32'(checksum), 32'd0);
      chk("reload_instruction", 32'(instruction), 32'h00);
      $display("txn reload state=%0d prog_len=%0d", state, prog_len);

      // Empty load returns to IDLE
      load_done = 1'b1; tick(); load_done = 1'b0;
      chk("empty_done_state", 32'(state), 32'd0);

      // Final write coincides with load_done
      load_start = 1'b1; tick(); load_start = 1'b0;
      wr_valid = 1'b1; wr_data = 8'hA5; tick();
      wr_data = 8'h5A; load_done = 1'b1; read_address = 8'd1; tick();
      wr_valid = 1'b0; load_done = 1'b0;
      chk("same_cycle_prog_len", 32'(prog_len), 32'd2);
      chk("same_cycle_state", 32'(state), 32'd2);
      tick();
      chk("same_cycle_rd1", 32'(instruction), 32'h5A);
      $display("txn done_with_write prog_len=%0d instruction=%02h", prog_len, instruction);

      // load_start beats load_done, from RUN and from LOAD
      load_start = 1'b1; load_done = 1'b1; tick();
      chk("prio_from_run", 32'(state), 32'd1);
      tick();
      load_start = 1'b0; load_done = 1'b0;
      chk("prio_in_load", 32'(state), 32'd1);
      chk("prio_prog_len", 32'(prog_len), 32'd0);
      $display("txn start_priority state=%0d", state);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
